// File: rtl/icc_pkg.sv
// Shared types and constants for the integer condition-code / branch unit.
package icc_pkg;

    // Bicc condition field encodings
    typedef enum logic [3:0] {
        BN   = 4'b0000,
        BE   = 4'b0001,
        BLE  = 4'b0010,
        BL   = 4'b0011,
        BLEU = 4'b0100,
        BCS  = 4'b0101,
        BNEG = 4'b0110,
        BVS  = 4'b0111,
        BA   = 4'b1000,
        BNE  = 4'b1001,
        BG   = 4'b1010,
        BGE  = 4'b1011,
        BGU  = 4'b1100,
        BCC  = 4'b1101,
        BPOS = 4'b1110,
        BVC  = 4'b1111
    } cond_e;

    // Branch sequencer states: waiting for a branch, or waiting for its delay slot
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_e;

    // Bit positions of the flags inside the {N,Z,C,V} icc vector
    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_C = 1;
    localparam int ICC_V = 0;

    // Position of the set-flags bit in the ALU opcode
    localparam int S_BIT = 4;

    // True when the ALU is writing the condition codes this cycle
    function automatic logic flag_write(input logic valid, input logic [5:0] opcode);
        return valid && opcode[S_BIT];
    endfunction

endpackage

// File: rtl/icc_cond_eval.sv
// Combinational Bicc condition evaluator: (cond, icc) -> taken.
// Codes 1001..1111 are the complements of 0001..0111, and BA (1000) is the
// complement of BN (0000), so only the low three bits select a base test.
module icc_cond_eval
    import icc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] icc,
    output logic       taken
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic base_s;

    assign n_s = icc[ICC_N];
    assign z_s = icc[ICC_Z];
    assign c_s = icc[ICC_C];
    assign v_s = icc[ICC_V];

    // Select the base test from the low bits, then optionally invert it
    always_comb begin
        base_s = 1'b0;
        case (cond[2:0])
            3'b000:  base_s = 1'b0;
            3'b001:  base_s = z_s;
            3'b010:  base_s = z_s | (n_s ^ v_s);
            3'b011:  base_s = n_s ^ v_s;
            3'b100:  base_s = c_s | z_s;
            3'b101:  base_s = c_s;
            3'b110:  base_s = n_s;
            3'b111:  base_s = v_s;
            default: base_s = 1'b0;
        endcase
        if (cond[3]) begin
            taken = ~base_s;
        end else begin
            taken = base_s;
        end
    end

endmodule

// File: rtl/icc_branch_unit.sv
// Integer condition-code register and delayed-branch resolver.
// Optional feature macro: ICC_FWD_EN -- when defined, a branch accepted in the
// same cycle as a flag-setting ALU op evaluates on the incoming flags; when
// undefined, br_ready drops for that cycle and the branch evaluates one cycle
// later against the updated icc register.
module icc_branch_unit
    import icc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [5:0]        alu_opcode,
    input  logic              N,
    input  logic              Z,
    input  logic              C,
    input  logic              V,
    input  logic              br_valid,
    input  logic [3:0]        br_cond,
    input  logic              br_annul,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    input  logic              slot_valid,
    output logic [3:0]        icc,
    output logic              annul_slot,
    output logic              redirect,
    output logic [ADDR_W-1:0] target_pc
);

    state_e            state_q;
    state_e            state_d;
    logic [3:0]        icc_q;
    logic [3:0]        icc_d;
    logic [ADDR_W-1:0] target_pc_q;
    logic [ADDR_W-1:0] target_pc_d;
    logic              taken_q;
    logic              taken_d;
    logic              annul_slot_q;
    logic              annul_slot_d;
    logic              redirect_q;
    logic              redirect_d;

    logic              flag_wr_s;
    logic              gate_s;
    logic [3:0]        eval_icc_s;
    logic              taken_s;
    logic              accept_s;
    logic              unused_opcode_s;

    // Only the S bit of the opcode matters to this unit
    assign unused_opcode_s = ^{alu_opcode[5], alu_opcode[3:0]};

    assign flag_wr_s = flag_write(alu_valid, alu_opcode);

`ifdef ICC_FWD_EN
    // Forward the incoming flags so a coincident branch needs no stall
    always_comb begin
        gate_s = 1'b0;
        if (flag_wr_s) begin
            eval_icc_s = {N, Z, C, V};
        end else begin
            eval_icc_s = icc_q;
        end
    end
`else
    // Stall the branch for one cycle while the icc register is being written
    always_comb begin
        gate_s     = flag_wr_s;
        eval_icc_s = icc_q;
    end
`endif

    icc_cond_eval u_cond_eval (
        .cond  (br_cond),
        .icc   (eval_icc_s),
        .taken (taken_s)
    );

    assign br_ready = !reset && (state_q == IDLE) && !gate_s;
    assign accept_s = br_valid && br_ready;

    // Next-state logic for the flags and the branch/delay-slot sequencer
    always_comb begin
        state_d      = state_q;
        target_pc_d  = target_pc_q;
        taken_d      = taken_q;
        annul_slot_d = annul_slot_q;
        redirect_d   = 1'b0;

        if (flag_wr_s) begin
            icc_d = {N, Z, C, V};
        end else begin
            icc_d = icc_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d      = SLOT;
                    target_pc_d  = br_target;
                    taken_d      = taken_s;
                    annul_slot_d = br_annul && (!taken_s || (br_cond == BA));
                end else begin
                    annul_slot_d = 1'b0;
                end
            end
            SLOT: begin
                if (slot_valid) begin
                    state_d      = IDLE;
                    redirect_d   = taken_q;
                    annul_slot_d = 1'b0;
                end else begin
                    state_d = SLOT;
                end
            end
            default: begin
                state_d      = IDLE;
                annul_slot_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any pending branch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            icc_q        <= 4'b0000;
            target_pc_q  <= {ADDR_W{1'b0}};
            taken_q      <= 1'b0;
            annul_slot_q <= 1'b0;
            redirect_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            icc_q        <= icc_d;
            target_pc_q  <= target_pc_d;
            taken_q      <= taken_d;
            annul_slot_q <= annul_slot_d;
            redirect_q   <= redirect_d;
        end
    end

    assign icc        = icc_q;
    assign annul_slot = annul_slot_q;
    assign redirect   = redirect_q;
    assign target_pc  = target_pc_q;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed self-checking bench for icc_branch_unit.
module tb_icc_branch_unit;

    localparam int ADDR_W = 32;
    localparam logic [5:0] OP_ADDCC = 6'b010000;
    localparam logic [5:0] OP_ADD   = 6'b000000;

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic [5:0]        alu_opcode;
    logic              alu_n;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;
    logic              br_valid;
    logic [3:0]        br_cond;
    logic              br_annul;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic              slot_valid;
    logic [3:0]        icc;
    logic              annul_slot;
    logic              redirect;
    logic [ADDR_W-1:0] target_pc;

    logic [3:0]        ref_cond;
    logic [3:0]        ref_icc;
    logic              ref_taken_s;

    int vectors = 0;
    int errors  = 0;

    icc_branch_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_opcode (alu_opcode),
        .N          (alu_n),
        .Z          (alu_z),
        .C          (alu_c),
        .V          (alu_v),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .br_annul   (br_annul),
        .br_target  (br_target),
        .br_ready   (br_ready),
        .slot_valid (slot_valid),
        .icc        (icc),
        .annul_slot (annul_slot),
        .redirect   (redirect),
        .target_pc  (target_pc)
    );

    icc_cond_eval u_ref (
        .cond  (ref_cond),
        .icc   (ref_icc),
        .taken (ref_taken_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Bench-side truth table for the Bicc conditions, written case by case
    function automatic logic exp_taken(input logic [3:0] cnd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cnd)
            4'd0:    return 1'b0;
            4'd1:    return z;
            4'd2:    return z | (n ^ v);
            4'd3:    return n ^ v;
            4'd4:    return c | z;
            4'd5:    return c;
            4'd6:    return n;
            4'd7:    return v;
            4'd8:    return 1'b1;
            4'd9:    return !z;
            4'd10:   return !(z | (n ^ v));
            4'd11:   return !(n ^ v);
            4'd12:   return !(c | z);
            4'd13:   return !c;
            4'd14:   return !n;
            4'd15:   return !v;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One ALU cycle with the given opcode and {N,Z,C,V}
    task automatic alu_op(input logic [5:0] op, input logic [3:0] f);
        alu_valid  = 1'b1;
        alu_opcode = op;
        {alu_n, alu_z, alu_c, alu_v} = f;
        step();
        alu_valid = 1'b0;
    endtask

    // Present a branch, wait (bounded) for accept, issue the slot, sample results.
    // Any ALU op already driven is withdrawn after the first edge.
    task automatic branch(input logic [3:0] cnd, input logic ann_bit, input logic [31:0] tgt,
                          output logic acc, output int cycles, output logic ann,
                          output logic red, output logic [31:0] tpc,
                          output logic rdy_after, output logic red2);
        br_valid  = 1'b1;
        br_cond   = cnd;
        br_annul  = ann_bit;
        br_target = tgt;
        acc       = 1'b0;
        cycles    = 0;
        while (!acc && cycles < 4) begin
            @(negedge clk);
            acc = br_ready;
            step();
            alu_valid = 1'b0;
            cycles++;
        end
        br_valid = 1'b0;
        @(negedge clk);
        ann = annul_slot;
        slot_valid = 1'b1;
        step();
        slot_valid = 1'b0;
        @(negedge clk);
        red       = redirect;
        tpc       = target_pc;
        rdy_after = br_ready;
        step();
        @(negedge clk);
        red2 = redirect;
        step();
    endtask

    logic        acc;
    int          cyc;
    logic        ann;
    logic        red;
    logic [31:0] tpc;
    logic        rdy;
    logic        red2;

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_opcode = 6'b000000;
        alu_n = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
        br_valid = 1'b0; br_cond = 4'b0000; br_annul = 1'b0; br_target = 32'h0;
        slot_valid = 1'b0; ref_cond = 4'b0000; ref_icc = 4'b0000;

        // Reset state
        step();
        @(negedge clk);
        check("rst br_ready", {31'b0, br_ready}, 32'd0);
        check("rst annul", {31'b0, annul_slot}, 32'd0);
        check("rst redirect", {31'b0, redirect}, 32'd0);
        check("rst icc", {28'b0, icc}, 32'd0);
        check("rst target", target_pc, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post-rst br_ready", {31'b0, br_ready}, 32'd1);
        step();

        // ADD without S: icc unchanged, BE not taken
        alu_op(OP_ADD, 4'b0110);
        check("noS icc", {28'b0, icc}, 32'h0);
        branch(4'b0001, 1'b0, 32'h80, acc, cyc, ann, red, tpc, rdy, red2);
        check("noS accept", {31'b0, acc}, 32'd1);
        check("noS redirect", {31'b0, red}, 32'd0);
        check("noS redirect2", {31'b0, red2}, 32'd0);

        // ADDcc 0xFFFFFFFF+1 -> Z=1 C=1, then BE taken to 0x100
        alu_op(OP_ADDCC, 4'b0110);
        check("addcc icc", {28'b0, icc}, 32'h6);
        branch(4'b0001, 1'b0, 32'h100, acc, cyc, ann, red, tpc, rdy, red2);
        check("be accept", {31'b0, acc}, 32'd1);
        check("be accept cycles", cyc, 32'd1);
        check("be annul", {31'b0, ann}, 32'd0);
        check("be redirect", {31'b0, red}, 32'd1);
        check("be target", tpc, 32'h100);
        check("be ready after", {31'b0, rdy}, 32'd1);
        check("be redirect2", {31'b0, red2}, 32'd0);

        // Annul behaviour
        branch(4'b0000, 1'b1, 32'h200, acc, cyc, ann, red, tpc, rdy, red2);
        check("bn,a annul", {31'b0, ann}, 32'd1);
        check("bn,a redirect", {31'b0, red}, 32'd0);
        branch(4'b1000, 1'b1, 32'h240, acc, cyc, ann, red, tpc, rdy, red2);
        check("ba,a annul", {31'b0, ann}, 32'd1);
        check("ba,a redirect", {31'b0, red}, 32'd1);
        check("ba,a target", tpc, 32'h240);
        alu_op(OP_ADDCC, 4'b0000);
        branch(4'b1001, 1'b1, 32'h280, acc, cyc, ann, red, tpc, rdy, red2);
        check("bne,a annul", {31'b0, ann}, 32'd0);
        check("bne,a redirect", {31'b0, red}, 32'd1);
        check("bne,a target", tpc, 32'h280);
        branch(4'b0001, 1'b1, 32'h2c0, acc, cyc, ann, red, tpc, rdy, red2);
        check("be,a untaken annul", {31'b0, ann}, 32'd1);
        check("be,a untaken redirect", {31'b0, red}, 32'd0);

        // Flag write coincident with branch: old Z=0, new Z=1, BE
        alu_op(OP_ADDCC, 4'b0000);
        alu_valid  = 1'b1;
        alu_opcode = OP_ADDCC;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0100;
        branch(4'b0001, 1'b0, 32'h300, acc, cyc, ann, red, tpc, rdy, red2);
        check("fwd accept", {31'b0, acc}, 32'd1);
`ifdef ICC_FWD_EN
        check("fwd accept cycles", cyc, 32'd1);
`else
        check("fwd accept cycles", cyc, 32'd2);
`endif
        check("fwd redirect", {31'b0, red}, 32'd1);
        check("fwd target", tpc, 32'h300);
        check("fwd icc", {28'b0, icc}, 32'h4);

        // Full condition sweep against the bench table and the reference evaluator
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 16; i++) begin
                ref_cond = 4'(c);
                ref_icc  = 4'(i);
                #1;
                check($sformatf("ref c=%0d i=%0d", c, i), {31'b0, ref_taken_s},
                      {31'b0, exp_taken(4'(c), 4'(i))});
                alu_op(OP_ADDCC, 4'(i));
                branch(4'(c), 1'b0, 32'h1000 + 32'(c * 16 + i), acc, cyc, ann, red, tpc, rdy, red2);
                check($sformatf("sweep acc c=%0d i=%0d", c, i), {31'b0, acc}, 32'd1);
                check($sformatf("sweep c=%0d i=%0d", c, i), {31'b0, red},
                      {31'b0, exp_taken(4'(c), 4'(i))});
                check($sformatf("sweep tgt c=%0d i=%0d", c, i), tpc, 32'h1000 + 32'(c * 16 + i));
            end
        end

        // Reset while in SLOT drops the branch; branch in SLOT is ignored
        alu_op(OP_ADDCC, 4'b1111);
        br_valid = 1'b1; br_cond = 4'b1000; br_annul = 1'b1; br_target = 32'h500;
        @(negedge clk);
        check("slotrst ready", {31'b0, br_ready}, 32'd1);
        step();
        br_cond = 4'b0000; br_target = 32'h999;
        @(negedge clk);
        check("slotrst annul", {31'b0, annul_slot}, 32'd1);
        check("slotrst busy", {31'b0, br_ready}, 32'd0);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        check("slot ignores br", target_pc, 32'h500);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("slotrst icc", {28'b0, icc}, 32'h0);
        check("slotrst annul clr", {31'b0, annul_slot}, 32'd0);
        check("slotrst redirect", {31'b0, redirect}, 32'd0);
        check("slotrst ready in rst", {31'b0, br_ready}, 32'd0);
        check("slotrst target", target_pc, 32'h0);
        step();
        reset = 1'b0;
        slot_valid = 1'b1;
        @(negedge clk);
        check("slotrst ready after", {31'b0, br_ready}, 32'd1);
        step();
        slot_valid = 1'b0;
        @(negedge clk);
        check("slotrst no redirect", {31'b0, redirect}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
